branch_resolve_ctrl: RTL and testbench
======================================

Name: branch_resolve_ctrl

Overview:
- ID-stage controller that sequences the branch equality comparator in the 5-stage MIPS pipeline.
- Detects data hazards on a beq/bne's rs/rt operands and inserts 0, 1 or 2 stall cycles.
- Drives the comparator operand forwarding muxes and resolves the branch.
- Issues pc_src and flush_ifid in the resolve cycle.

Parameters:
- REG_ADDR_W, 5: register-index width.
- STAT_W, 32: statistics counter width (optional feature only).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- pipe_hold  in  1  external pipeline freeze (e.g. memory wait); FSM holds.
- branch_valid  in  1  ID holds a beq/bne.
- branch_ne  in  1  1 = bne, 0 = beq.
- id_rs, id_rt  in  REG_ADDR_W  branch source registers.
- ex_regwrite, ex_memread  in  1  ID/EX control bits.
- ex_rd  in  REG_ADDR_W  ID/EX destination.
- mem_regwrite, mem_memread  in  1  EX/MEM control bits.
- mem_rd  in  REG_ADDR_W  EX/MEM destination.
- wb_regwrite  in  1  MEM/WB control bit.
- wb_rd  in  REG_ADDR_W  MEM/WB destination.
- cmp_eq  in  1  comparator result on the forwarded operands.
- fwd_a_sel, fwd_b_sel  out  2  comparator operand select: 00 regfile, 01 EX/MEM ALU result, 10 MEM/WB result.
- stall  out  1  freeze PC and IF/ID, bubble into ID/EX.
- pc_src  out  1  select branch target.
- flush_ifid  out  1  squash the fetched instruction.

Behaviour:
- Reset: while rst_n = 0, state = IDLE, cnt = 0, and all outputs are 0 regardless of inputs.
- Per-operand need, for r in {rs, rt}:
  - r == 0: need 0.
  - ex_regwrite & ex_rd == r: need 2 if ex_memread, else 1.
  - else mem_regwrite & mem_memread & mem_rd == r: need 1.
  - else: need 0.
  - N = max(need_rs, need_rt).
- Forward select, evaluated in the resolve cycle only (00 otherwise):
  - 01 if mem_regwrite & !mem_memread & mem_rd == r & r != 0.
  - else 10 if wb_regwrite & wb_rd == r & r != 0.
  - else 00.
  - EX/MEM has priority over MEM/WB.
- taken = branch_ne ? !cmp_eq : cmp_eq. In the resolve cycle, pc_src = flush_ifid = taken. Both are 0 in all other cycles.
- FSM states: IDLE, STALL. cnt is 2 bits.
  - IDLE, !branch_valid: all outputs 0.
  - IDLE, branch_valid, N = 0: resolve this cycle (stall = 0), stay IDLE.
  - IDLE, branch_valid, N > 0: stall = 1, next state STALL, cnt <= N-1.
  - STALL, cnt != 0: stall = 1, cnt <= cnt-1.
  - STALL, cnt == 0: stall = 0, resolve, next state IDLE.
  - Net effect: N stall cycles, then a resolve cycle, i.e. resolve N cycles after the branch enters ID.
- pipe_hold = 1: state and cnt hold, and pc_src/flush_ifid are forced 0. The stall output keeps its state-derived value. Resolution happens in the first non-held cycle that meets the resolve condition.
- branch_valid dropping while in STALL (e.g. an upstream flush): next state IDLE, stall = 0, no resolve.
- Asynchronous reset mid-STALL: immediate IDLE, outputs 0. The pending branch is abandoned.
- All outputs are combinational from state, cnt and inputs. No output registers.

Optional Feature:
- Macro BRANCH_STATS_EN.
- Defined: adds outputs stat_branches, stat_taken and stat_stall_cycles, each STAT_W bits.
  - stat_branches increments on each resolve.
  - stat_taken increments on each resolve with taken = 1.
  - stat_stall_cycles increments on each cycle with stall = 1 and pipe_hold = 0.
  - All three saturate at all-ones and reset to 0.
- Undefined: the ports and counters are absent. Core behaviour is identical.

Decomposition:
- Shared package mips_pkg holds:
  - FWD_RF = 2'b00, FWD_EXMEM = 2'b01, FWD_MEMWB = 2'b10.
  - The branch FSM state enum (IDLE, STALL).
  - REG_ZERO constant.
- Sub-module branch_operand_chk, instantiated once per operand. Input: one source register plus the pipeline destination/control bits. Outputs: 2-bit need and 2-bit forward select. Top level takes the max of the two needs and runs the FSM.

Test Plan:
- beq r3,r4, no producers, cmp_eq = 1 -> same cycle: stall 0, pc_src 1, flush_ifid 1, fwd 00/00.
- add r3 in EX, beq r3,r4 -> cycle0 stall 1; cycle1 (add now in MEM) stall 0, fwd_a_sel 01, resolve.
- lw r4 in EX, bne r5,r4, cmp_eq = 1 -> cycles 0-1 stall 1; cycle2 fwd_b_sel 10, pc_src 0, flush 0.
- ex_regwrite = 1, ex_rd = 0, beq r0,r0 -> no stall, taken on cmp_eq = 1.
- lw hazard, pipe_hold = 1 for 3 cycles starting at cycle1 -> stall held, cnt frozen, resolve 3 cycles late; stats (if enabled) count 2 stall cycles.
- rst_n low during STALL -> all outputs 0 immediately; after release with branch_valid = 0 -> stays IDLE.

Source files
------------

// File: rtl/mips_pkg.sv
// Constants and types shared by the MIPS pipeline control blocks.
// Used here by the branch resolution controller and its operand hazard checker.
package mips_pkg;

  // Comparator operand source select encodings
  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic {
    IDLE  = 1'b0,
    STALL = 1'b1
  } br_state_e;

  function automatic logic [1:0] max_need(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/branch_operand_chk.sv
// Hazard/forwarding check for one branch source register: reports how many
// stall cycles the operand needs and which pipeline stage should feed it.
module branch_operand_chk
  import mips_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] src,
  input  logic                  ex_regwrite,
  input  logic                  ex_memread,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  mem_regwrite,
  input  logic                  mem_memread,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  wb_regwrite,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  output logic [1:0]            need,
  output logic [1:0]            fwd_sel
);

  logic nonzero;
  logic ex_hit;
  logic mem_hit;
  logic wb_hit;

  assign nonzero = (src != REG_ADDR_W'(REG_ZERO));
  assign ex_hit  = ex_regwrite  && (ex_rd  == src);
  assign mem_hit = mem_regwrite && (mem_rd == src);
  assign wb_hit  = wb_regwrite  && (wb_rd  == src);

  // NOTE: every output gets a default at the top of the block so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    need    = 2'd0;
    fwd_sel = FWD_RF;
    if (nonzero) begin
      // A load in EX is two cycles from being forwardable; an ALU op in EX or a
      // load in MEM is one cycle away.
      if (ex_hit) begin
        need = ex_memread ? 2'd2 : 2'd1;
      end else if (mem_hit && mem_memread) begin
        need = 2'd1;
      end

      if (mem_hit && !mem_memread) begin
        fwd_sel = FWD_EXMEM;
      end else if (wb_hit) begin
        fwd_sel = FWD_MEMWB;
      end
    end
  end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// ID-stage beq/bne controller: stalls on operand hazards, then steers the
// comparator forwarding muxes and redirects fetch. Statistics via BRANCH_STATS_EN.
module branch_resolve_ctrl
  import mips_pkg::*;
#(
  parameter int REG_ADDR_W = 5
`ifdef BRANCH_STATS_EN
  ,
  parameter int STAT_W = 32
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pipe_hold,
  input  logic                  branch_valid,
  input  logic                  branch_ne,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  ex_regwrite,
  input  logic                  ex_memread,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  mem_regwrite,
  input  logic                  mem_memread,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  wb_regwrite,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  cmp_eq,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel,
  output logic                  stall,
  output logic                  pc_src,
  output logic                  flush_ifid
`ifdef BRANCH_STATS_EN
  ,
  output logic [STAT_W-1:0]     stat_branches,
  output logic [STAT_W-1:0]     stat_taken,
  output logic [STAT_W-1:0]     stat_stall_cycles
`endif
);

  br_state_e  state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [1:0] need_rs, need_rt, need_max;
  logic [1:0] fwd_rs, fwd_rt;
  logic       stall_raw;
  logic       resolve_cond;
  logic       resolve;
  logic       taken;

  branch_operand_chk #(.REG_ADDR_W(REG_ADDR_W)) u_chk_rs (
    .src          (id_rs),
    .ex_regwrite  (ex_regwrite),
    .ex_memread   (ex_memread),
    .ex_rd        (ex_rd),
    .mem_regwrite (mem_regwrite),
    .mem_memread  (mem_memread),
    .mem_rd       (mem_rd),
    .wb_regwrite  (wb_regwrite),
    .wb_rd        (wb_rd),
    .need         (need_rs),
    .fwd_sel      (fwd_rs)
  );

  branch_operand_chk #(.REG_ADDR_W(REG_ADDR_W)) u_chk_rt (
    .src          (id_rt),
    .ex_regwrite  (ex_regwrite),
    .ex_memread   (ex_memread),
    .ex_rd        (ex_rd),
    .mem_regwrite (mem_regwrite),
    .mem_memread  (mem_memread),
    .mem_rd       (mem_rd),
    .wb_regwrite  (wb_regwrite),
    .wb_rd        (wb_rd),
    .need         (need_rt),
    .fwd_sel      (fwd_rt)
  );

  assign need_max = max_need(need_rs, need_rt);
  assign taken    = branch_ne ? !cmp_eq : cmp_eq;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    stall_raw    = 1'b0;
    resolve_cond = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (branch_valid) begin
          if (need_max == 2'd0) begin
            resolve_cond = 1'b1;
          end else begin
            stall_raw = 1'b1;
            state_d   = STALL;
            cnt_d     = need_max - 2'd1;
          end
        end
      end
      STALL: begin
        // A vanished branch (upstream flush) is dropped without resolving.
        if (!branch_valid) begin
          state_d = IDLE;
        end else if (cnt_q != 2'd0) begin
          stall_raw = 1'b1;
          cnt_d     = cnt_q - 2'd1;
        end else begin
          resolve_cond = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (pipe_hold) begin
      state_d = state_q;
      cnt_d   = cnt_q;
    end
  end

  // Outputs are forced low while reset is asserted, even though they are
  // combinational from live inputs.
  assign resolve    = resolve_cond && !pipe_hold && rst_n;
  assign stall      = stall_raw && rst_n;
  assign pc_src     = resolve && taken;
  assign flush_ifid = resolve && taken;
  assign fwd_a_sel  = resolve ? fwd_rs : FWD_RF;
  assign fwd_b_sel  = resolve ? fwd_rt : FWD_RF;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, and the asynchronous reset sits in the sensitivity list.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef BRANCH_STATS_EN
  logic [STAT_W-1:0] branches_q, taken_q, stall_cyc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branches_q  <= '0;
      taken_q     <= '0;
      stall_cyc_q <= '0;
    end else begin
      if (resolve && (branches_q != '1)) begin
        branches_q <= branches_q + 1'b1;
      end
      if (resolve && taken && (taken_q != '1)) begin
        taken_q <= taken_q + 1'b1;
      end
      if (stall && !pipe_hold && (stall_cyc_q != '1)) begin
        stall_cyc_q <= stall_cyc_q + 1'b1;
      end
    end
  end

  assign stat_branches     = branches_q;
  assign stat_taken        = taken_q;
  assign stat_stall_cycles = stall_cyc_q;
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Scoreboard bench for branch_resolve_ctrl: each test pushes the expected
// per-cycle outputs and a negedge monitor pops and compares them.
module tb_branch_resolve_ctrl;

  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          pipe_hold, branch_valid, branch_ne;
  logic [AW-1:0] id_rs, id_rt, ex_rd, mem_rd, wb_rd;
  logic          ex_regwrite, ex_memread, mem_regwrite, mem_memread, wb_regwrite;
  logic          cmp_eq;
  logic [1:0]    fwd_a_sel, fwd_b_sel;
  logic          stall, pc_src, flush_ifid;
`ifdef BRANCH_STATS_EN
  logic [31:0]   stat_branches, stat_taken, stat_stall_cycles;
`endif

  typedef struct packed {
    logic       stall;
    logic       pc_src;
    logic       flush;
    logic [1:0] fa;
    logic [1:0] fb;
  } exp_t;

  typedef struct {
    exp_t  e;
    string name;
  } sb_t;

  sb_t sb_q[$];
  int  n_assert = 0;
  int  n_fail   = 0;

  always #5 clk = ~clk;

  branch_resolve_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pipe_hold    (pipe_hold),
    .branch_valid (branch_valid),
    .branch_ne    (branch_ne),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .ex_regwrite  (ex_regwrite),
    .ex_memread   (ex_memread),
    .ex_rd        (ex_rd),
    .mem_regwrite (mem_regwrite),
    .mem_memread  (mem_memread),
    .mem_rd       (mem_rd),
    .wb_regwrite  (wb_regwrite),
    .wb_rd        (wb_rd),
    .cmp_eq       (cmp_eq),
    .fwd_a_sel    (fwd_a_sel),
    .fwd_b_sel    (fwd_b_sel),
    .stall        (stall),
    .pc_src       (pc_src),
    .flush_ifid   (flush_ifid)
`ifdef BRANCH_STATS_EN
    ,
    .stat_branches     (stat_branches),
    .stat_taken        (stat_taken),
    .stat_stall_cycles (stat_stall_cycles)
`endif
  );

  // Scoreboard monitor: outputs are compared on the falling edge, mid-cycle.
  always @(negedge clk) begin
    if (sb_q.size() != 0) begin
      sb_t  ent;
      exp_t act;
      ent = sb_q.pop_front();
      act = {stall, pc_src, flush_ifid, fwd_a_sel, fwd_b_sel};
      n_assert++;
      if (act !== ent.e) begin
        n_fail++;
        $display("FAIL %s: got stall=%b pc_src=%b flush=%b fwd_a=%b fwd_b=%b, expected stall=%b pc_src=%b flush=%b fwd_a=%b fwd_b=%b",
                 ent.name, act.stall, act.pc_src, act.flush, act.fa, act.fb,
                 ent.e.stall, ent.e.pc_src, ent.e.flush, ent.e.fa, ent.e.fb);
      end
    end
  end

  function automatic exp_t mk(input logic s, input logic t, input logic [1:0] fa,
                              input logic [1:0] fb);
    mk = '{stall: s, pc_src: t, flush: t, fa: fa, fb: fb};
  endfunction

  task automatic clear();
    pipe_hold = 0; branch_valid = 0; branch_ne = 0;
    id_rs = 0; id_rt = 0; ex_rd = 0; mem_rd = 0; wb_rd = 0;
    ex_regwrite = 0; ex_memread = 0; mem_regwrite = 0; mem_memread = 0;
    wb_regwrite = 0; cmp_eq = 0;
  endtask

  // Inputs for the current cycle are already applied; record the expectation
  // and advance to just after the next rising edge.
  task automatic step(input string nm, input exp_t e);
    sb_q.push_back('{e: e, name: nm});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    clear();
    branch_valid = 1; id_rs = 3; ex_regwrite = 1; ex_memread = 1; ex_rd = 3; cmp_eq = 1;
    #3;
    sb_q.push_back('{e: mk(0, 0, 2'b00, 2'b00), name: "reset_outputs_zero"});
    @(negedge clk);
    #1;
    clear();
    rst_n = 1;
    @(posedge clk);
    #1;
    step("idle_after_reset", mk(0, 0, 2'b00, 2'b00));
  endtask

  task automatic test_no_hazard();
    clear();
    branch_valid = 1; id_rs = 3; id_rt = 4; cmp_eq = 1;
    step("beq_no_hazard_taken", mk(0, 1, 2'b00, 2'b00));
    cmp_eq = 0;
    step("beq_no_hazard_not_taken", mk(0, 0, 2'b00, 2'b00));
    clear();
    id_rs = 3; ex_regwrite = 1; ex_rd = 3; cmp_eq = 1;
    step("no_branch_no_outputs", mk(0, 0, 2'b00, 2'b00));
  endtask

  task automatic test_ex_alu_hazard();
    clear();
    branch_valid = 1; id_rs = 3; id_rt = 4; ex_regwrite = 1; ex_rd = 3;
    step("alu_hazard_stall", mk(1, 0, 2'b00, 2'b00));
    ex_regwrite = 0; mem_regwrite = 1; mem_rd = 3; cmp_eq = 1;
    step("alu_hazard_resolve_exmem", mk(0, 1, 2'b01, 2'b00));
  endtask

  task automatic test_load_use();
    clear();
    branch_valid = 1; branch_ne = 1; id_rs = 5; id_rt = 4;
    ex_regwrite = 1; ex_memread = 1; ex_rd = 4;
    step("load_use_stall0", mk(1, 0, 2'b00, 2'b00));
    ex_regwrite = 0; ex_memread = 0; mem_regwrite = 1; mem_memread = 1; mem_rd = 4;
    step("load_use_stall1", mk(1, 0, 2'b00, 2'b00));
    mem_regwrite = 0; mem_memread = 0; wb_regwrite = 1; wb_rd = 4; cmp_eq = 1;
    step("load_use_bne_not_taken", mk(0, 0, 2'b00, 2'b10));
  endtask

  task automatic test_zero_reg();
    clear();
    branch_valid = 1; ex_regwrite = 1; ex_memread = 1; ex_rd = 0;
    mem_regwrite = 1; mem_rd = 0; wb_regwrite = 1; wb_rd = 0; cmp_eq = 1;
    step("r0_no_stall_taken", mk(0, 1, 2'b00, 2'b00));
  endtask

  task automatic test_pipe_hold();
    clear();
    rst_n = 0;
    #2;
    rst_n = 1;
    branch_valid = 1; id_rs = 3; id_rt = 6; ex_regwrite = 1; ex_memread = 1; ex_rd = 3;
    step("hold_stall0", mk(1, 0, 2'b00, 2'b00));
    ex_regwrite = 0; ex_memread = 0; mem_regwrite = 1; mem_memread = 1; mem_rd = 3;
    pipe_hold = 1; cmp_eq = 1;
    for (int i = 0; i < 3; i++) step("hold_frozen", mk(1, 0, 2'b00, 2'b00));
    pipe_hold = 0;
    step("hold_released_stall", mk(1, 0, 2'b00, 2'b00));
    mem_regwrite = 0; mem_memread = 0; wb_regwrite = 1; wb_rd = 3;
    step("hold_late_resolve", mk(0, 1, 2'b10, 2'b00));
    clear();
    branch_valid = 1; id_rs = 7; id_rt = 8; cmp_eq = 1; pipe_hold = 1;
    step("hold_idle_no_resolve", mk(0, 0, 2'b00, 2'b00));
    pipe_hold = 0;
    step("hold_idle_then_resolve", mk(0, 1, 2'b00, 2'b00));
`ifdef BRANCH_STATS_EN
    n_assert++;
    if (stat_stall_cycles !== 32'd2) begin
      n_fail++;
      $display("FAIL stat_stall_cycles: got %0d, expected 2", stat_stall_cycles);
    end
    n_assert++;
    if (stat_branches !== 32'd2) begin
      n_fail++;
      $display("FAIL stat_branches: got %0d, expected 2", stat_branches);
    end
    n_assert++;
    if (stat_taken !== 32'd2) begin
      n_fail++;
      $display("FAIL stat_taken: got %0d, expected 2", stat_taken);
    end
`endif
  endtask

  task automatic test_branch_drop();
    clear();
    branch_valid = 1; id_rs = 3; ex_regwrite = 1; ex_memread = 1; ex_rd = 3;
    step("drop_stall", mk(1, 0, 2'b00, 2'b00));
    clear();
    step("drop_no_resolve", mk(0, 0, 2'b00, 2'b00));
    branch_valid = 1; id_rs = 9; id_rt = 10; cmp_eq = 1;
    step("drop_back_to_idle", mk(0, 1, 2'b00, 2'b00));
  endtask

  task automatic test_async_reset();
    clear();
    branch_valid = 1; id_rs = 3; id_rt = 4; ex_regwrite = 1; ex_memread = 1; ex_rd = 3;
    step("areset_stall0", mk(1, 0, 2'b00, 2'b00));
    ex_regwrite = 0; ex_memread = 0; mem_regwrite = 1; mem_memread = 1; mem_rd = 3; cmp_eq = 1;
    rst_n = 0;
    #1;
    n_assert++;
    if ({stall, pc_src, flush_ifid, fwd_a_sel, fwd_b_sel} !== 7'b0) begin
      n_fail++;
      $display("FAIL areset_immediate: got stall=%b pc_src=%b flush=%b fwd_a=%b fwd_b=%b, expected all 0",
               stall, pc_src, flush_ifid, fwd_a_sel, fwd_b_sel);
    end
    sb_q.push_back('{e: mk(0, 0, 2'b00, 2'b00), name: "areset_held_low"});
    @(negedge clk);
    #1;
    clear();
    rst_n = 1;
    @(posedge clk);
    #1;
    step("areset_idle0", mk(0, 0, 2'b00, 2'b00));
    step("areset_idle1", mk(0, 0, 2'b00, 2'b00));
    branch_valid = 1; id_rs = 3; id_rt = 4; cmp_eq = 1;
    step("areset_fresh_branch", mk(0, 1, 2'b00, 2'b00));
  endtask

  task automatic test_back_to_back();
    clear();
    branch_valid = 1; id_rs = 11; id_rt = 12; mem_regwrite = 1; mem_memread = 1; mem_rd = 12;
    step("b2b_mem_load_stall", mk(1, 0, 2'b00, 2'b00));
    mem_regwrite = 0; mem_memread = 0; wb_regwrite = 1; wb_rd = 12; cmp_eq = 0;
    step("b2b_beq_not_taken", mk(0, 0, 2'b00, 2'b10));
    clear();
    branch_valid = 1; branch_ne = 1; id_rs = 13; id_rt = 14; ex_regwrite = 1; ex_rd = 14;
    step("b2b_alu_stall", mk(1, 0, 2'b00, 2'b00));
    ex_regwrite = 0; mem_regwrite = 1; mem_rd = 14; wb_regwrite = 1; wb_rd = 14; cmp_eq = 0;
    step("b2b_exmem_priority", mk(0, 1, 2'b00, 2'b01));
    clear();
    branch_valid = 1; id_rs = 15; id_rt = 16;
    mem_regwrite = 1; mem_memread = 1; mem_rd = 15;
    ex_regwrite = 1; ex_memread = 1; ex_rd = 16;
    step("b2b_max_need_stall0", mk(1, 0, 2'b00, 2'b00));
    ex_regwrite = 0; ex_memread = 0; mem_rd = 16; wb_regwrite = 1; wb_rd = 15;
    step("b2b_max_need_stall1", mk(1, 0, 2'b00, 2'b00));
    mem_regwrite = 0; mem_memread = 0; wb_rd = 16; cmp_eq = 1;
    step("b2b_max_need_resolve", mk(0, 1, 2'b00, 2'b10));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_no_hazard();
    test_ex_alu_hazard();
    test_load_use();
    test_zero_reg();
    test_pipe_hold();
    test_branch_drop();
    test_async_reset();
    test_back_to_back();
    clear();
    step("final_idle", mk(0, 0, 2'b00, 2'b00));
    for (int i = 0; i < 4 && sb_q.size() != 0; i++) @(negedge clk);
    #1;
    n_assert++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
